// File: rtl/xorn_pkg.sv
// Shared types and helpers for the XOR checksum block.
package xorn_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } xorn_state_t;

    // Saturating increment: stops at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] x, input logic [31:0] max_val);
        return (x >= max_val) ? max_val : x + 32'd1;
    endfunction

endpackage

// File: rtl/xorn_checksum.sv
// Framed running XOR checksum with valid/ready on input and result sides.
// Delivers the frame checksum, its parity and a saturating word count.
module xorn_checksum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             last_i,
    output logic             ready_o,
    input  logic             clear_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             parity_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i
);
    import xorn_pkg::*;

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    xorn_state_t      state;
    xorn_state_t      state_nx;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic [WIDTH-1:0] acc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             beat;

    // Handshake, next-state, and the accumulator update (clear discards old contents first).
    always_comb begin
        ready_o  = (state == ST_ACC);
        beat     = valid_i && ready_o;
        acc_base = clear_i ? '0 : acc;
        cnt_base = clear_i ? '0 : cnt;
        acc_nx   = acc_base ^ data_i;
        cnt_nx   = CNT_W'(sat_inc(32'(cnt_base), CNT_MAX));
        state_nx = state;
        case (state)
            ST_ACC:  if (beat && last_i) state_nx = ST_DONE;
            ST_DONE: if (sum_ready_i)    state_nx = ST_ACC;
            default: state_nx = ST_ACC;
        endcase
    end

    // State, running accumulator/count and the held result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_ACC;
            acc         <= '0;
            cnt         <= '0;
            sum_o       <= '0;
            count_o     <= '0;
            sum_valid_o <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_ACC: begin
                    if (beat && last_i) begin
                        sum_o       <= acc_nx;
                        count_o     <= cnt_nx;
                        sum_valid_o <= 1'b1;
                        acc         <= '0;
                        cnt         <= '0;
                    end else if (beat) begin
                        acc <= acc_nx;
                        cnt <= cnt_nx;
                    end else if (clear_i) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                ST_DONE: begin
                    if (sum_ready_i) sum_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign parity_o = ^sum_o;

endmodule
